heap_node_ctrl: RTL and testbench

Sequencer for one level of the pipelined heap sorter. It accepts a sift-down command from the level above and reads the two candidate children from the next level's left/right data store. It writes the winner into its own level's data store and forwards the displaced value downward. One instance sits between each pair of adjacent data-store levels. The instance with `LAST=1` terminates the chain.

---
 rtl/heap_node_ctrl_pkg.sv | 52 +++++
 rtl/heap_node_ctrl_if.sv | 27 ++
 rtl/heap_node_ctrl_key_cmp.sv | 43 ++++
 rtl/heap_node_ctrl.sv | 145 ++++++++++++++
 tb/tb_heap_node_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/heap_node_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// heap_node_ctrl_pkg
// Shared definitions for every level of the pipelined heap sorter:
//   - state_t     : node sequencer states (STATE_*)
//   - sel_t       : winner code returned by the 3-way key compare
//   - node_dbg_t  : debug view of a node (current state + level index)
//   - EMPTY_KEY   : key value marking an empty slot
//   - key_of()    : extracts the unsigned compare key from the top of a word
// No ports (package).
// -----------------------------------------------------------------------------
package heap_node_ctrl_pkg;

    typedef enum logic [2:0] {
        STATE_IDLE = 3'd0,
        STATE_RD   = 3'd1,
        STATE_CMP  = 3'd2,
        STATE_FWD  = 3'd3,
        STATE_WAIT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SEL_V = 2'd0,
        SEL_L = 2'd1,
        SEL_R = 2'd2
    } sel_t;

    typedef struct packed {
        state_t     state;
        logic [7:0] level;
    } node_dbg_t;

    // key_of() works on words up to this width; callers zero-extend.
    localparam int DATA_MAX = 64;
    localparam int KEY_MAX  = 64;

    localparam logic [KEY_MAX-1:0] EMPTY_KEY = '0;

    // Key is data[data_width-1 -: key_width]; widths are elaboration
    // constants at every call site, so the shifts reduce to wiring.
    function automatic logic [KEY_MAX-1:0] key_of(
        input logic [DATA_MAX-1:0] data,
        input int unsigned         data_width,
        input int unsigned         key_width
    );
        logic [DATA_MAX-1:0] w_shifted;
        logic [KEY_MAX-1:0]  w_mask;
        w_shifted = data >> (data_width - key_width);
        w_mask    = {KEY_MAX{1'b1}} >> (KEY_MAX - key_width);
        return w_shifted[KEY_MAX-1:0] & w_mask;
    endfunction

endpackage

// File: rtl/heap_node_ctrl_if.sv
// -----------------------------------------------------------------------------
// heap_node_ctrl_if
// Sift-down command channel between two adjacent heap levels.
//   valid/ready : a command transfers on a rising clk edge where both are 1.
//                 Once valid is raised, the master holds valid, data, addr and
//                 branch stable until that edge; ready may be 1 or 0 at any
//                 time and never depends on valid.
//   data        : value being sifted
//   addr        : pair index in the receiving level
//   branch      : 0 = left store, 1 = right store
//   done        : one-cycle pulse from the receiver when its own write issues
// Modports: master (sender, upper level), slave (receiver, lower level).
// -----------------------------------------------------------------------------
interface heap_node_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  branch;
    logic                  done;

    modport master (output valid, data, addr, branch, input  ready, done);
    modport slave  (input  valid, data, addr, branch, output ready, done);
endinterface

// File: rtl/heap_node_ctrl_key_cmp.sv
// -----------------------------------------------------------------------------
// heap_key_cmp
// Combinational 3-way max used by each heap level.
//   i_v   : value being sifted
//   i_l   : left child
//   i_r   : right child
//   o_win : winning word
//   o_sel : SEL_V, SEL_L or SEL_R
// Ties: left beats right, and v beats the better child (v stays put when
// equal). An empty key (0) never beats anything.
// -----------------------------------------------------------------------------
module heap_key_cmp
    import heap_node_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 16
) (
    input  logic [DATA_WIDTH-1:0] i_v,
    input  logic [DATA_WIDTH-1:0] i_l,
    input  logic [DATA_WIDTH-1:0] i_r,
    output logic [DATA_WIDTH-1:0] o_win,
    output sel_t                  o_sel
);
    logic [KEY_MAX-1:0] w_kv, w_kl, w_kr, w_kc;
    logic               w_c_is_r;

    assign w_kv = key_of(DATA_MAX'(i_v), DATA_WIDTH, KEY_WIDTH);
    assign w_kl = key_of(DATA_MAX'(i_l), DATA_WIDTH, KEY_WIDTH);
    assign w_kr = key_of(DATA_MAX'(i_r), DATA_WIDTH, KEY_WIDTH);

    always_comb begin
        o_win    = i_v;
        o_sel    = SEL_V;
        // Strictly greater: a tie between the children goes left.
        w_c_is_r = (w_kr > w_kl);
        w_kc     = w_c_is_r ? w_kr : w_kl;
        // Two empty children can never displace v, whatever v holds.
        if ((w_kc != EMPTY_KEY) && (w_kv < w_kc)) begin
            o_win = w_c_is_r ? i_r : i_l;
            o_sel = w_c_is_r ? SEL_R : SEL_L;
        end
    end
endmodule

// File: rtl/heap_node_ctrl.sv
// -----------------------------------------------------------------------------
// heap_node_ctrl
// Sequencer for one level of the pipelined heap sorter. Accepts a sift-down
// command, reads both children from the level below, writes the winner into
// its own level and forwards the displaced value downward.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   up          : command from the upper node (slave side); up.done pulses
//                 with the own-level write
//   dn          : command to the lower node (master side)
//   ch_addr     : read address to the child level's left/right store
//   ch_rdata_l/r: child data, one-cycle synchronous read
//   st_*        : own-level store write port
//   dbg         : current state and level index
// LAST=1 terminates the chain: children are treated as empty, so the node
// never reads and never forwards.
// -----------------------------------------------------------------------------
module heap_node_ctrl
    import heap_node_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEY_WIDTH  = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int LEVEL      = 1,
    parameter int LAST       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    heap_node_ctrl_if.slave       up,
    heap_node_ctrl_if.master      dn,
    output logic [ADDR_WIDTH-1:0] ch_addr,
    input  logic [DATA_WIDTH-1:0] ch_rdata_l,
    input  logic [DATA_WIDTH-1:0] ch_rdata_r,
    output logic [DATA_WIDTH-1:0] st_din,
    output logic [ADDR_WIDTH-2:0] st_addr,
    output logic                  st_we,
    output logic                  st_branch,
    output node_dbg_t             dbg
);
    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_v;
    logic [ADDR_WIDTH-2:0] r_addr;
    logic                  r_branch;
    logic [ADDR_WIDTH-1:0] r_ch_addr;
    logic [DATA_WIDTH-1:0] r_st_din;
    logic [ADDR_WIDTH-2:0] r_st_addr;
    logic                  r_st_we;
    logic                  r_st_branch;
    logic                  r_dn_valid;
    logic [DATA_WIDTH-1:0] r_dn_data;
    logic [ADDR_WIDTH-1:0] r_dn_addr;
    logic                  r_dn_branch;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_l, w_r, w_win;
    sel_t                  w_sel;

    // The last level has no children: feed empty words to the compare.
    assign w_l = (LAST != 0) ? '0 : ch_rdata_l;
    assign w_r = (LAST != 0) ? '0 : ch_rdata_r;

    heap_key_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEY_WIDTH  (KEY_WIDTH)
    ) u_cmp (
        .i_v   (r_v),
        .i_l   (w_l),
        .i_r   (w_r),
        .o_win (w_win),
        .o_sel (w_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= STATE_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            STATE_IDLE: if (up.valid) begin
                w_accept = 1'b1;
                w_next   = (LAST != 0) ? STATE_CMP : STATE_RD;
            end
            STATE_RD:   w_next = STATE_CMP;
            STATE_CMP:  w_next = (w_sel == SEL_V) ? STATE_IDLE : STATE_FWD;
            STATE_FWD:  if (dn.ready) w_next = STATE_WAIT;
            // Wait for the child's own write so its next read sees new data.
            STATE_WAIT: if (dn.done) w_next = STATE_IDLE;
            default:    w_next = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v         <= '0;
            r_addr      <= '0;
            r_branch    <= 1'b0;
            r_ch_addr   <= '0;
            r_st_din    <= '0;
            r_st_addr   <= '0;
            r_st_we     <= 1'b0;
            r_st_branch <= 1'b0;
            r_dn_valid  <= 1'b0;
            r_dn_data   <= '0;
            r_dn_addr   <= '0;
            r_dn_branch <= 1'b0;
        end else begin
            r_st_we <= 1'b0;
            if (w_accept) begin
                r_v      <= up.data;
                r_addr   <= up.addr;
                r_branch <= up.branch;
                // Leave the child address quiet on the last level.
                if (LAST == 0) r_ch_addr <= {up.addr, up.branch};
            end
            if (r_state == STATE_CMP) begin
                r_st_we     <= 1'b1;
                r_st_din    <= w_win;
                r_st_addr   <= r_addr;
                r_st_branch <= r_branch;
                if (w_sel != SEL_V) begin
                    r_dn_valid  <= 1'b1;
                    r_dn_data   <= r_v;
                    r_dn_addr   <= r_ch_addr;
                    r_dn_branch <= (w_sel == SEL_R);
                end
            end
            if ((r_state == STATE_FWD) && dn.ready) r_dn_valid <= 1'b0;
        end
    end

    assign up.ready  = (r_state == STATE_IDLE);
    assign up.done   = r_st_we;
    assign ch_addr   = r_ch_addr;
    assign st_din    = r_st_din;
    assign st_addr   = r_st_addr;
    assign st_we     = r_st_we;
    assign st_branch = r_st_branch;
    assign dn.valid  = r_dn_valid;
    assign dn.data   = r_dn_data;
    assign dn.addr   = r_dn_addr;
    assign dn.branch = r_dn_branch;
    assign dbg       = '{state: r_state, level: 8'(LEVEL)};
endmodule

// File: tb/tb_heap_node_ctrl.sv
// -----------------------------------------------------------------------------
// tb_heap_node_ctrl
// Self-checking bench for heap_node_ctrl: a chained node (LAST=0) with a
// behavioural child store, plus a terminating node (LAST=1).
// -----------------------------------------------------------------------------
module tb_heap_node_ctrl;
    import heap_node_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT: chained node ----------------
    heap_node_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW-1)) up_if ();
    heap_node_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW))   dn_if ();
    logic [AW-1:0] ch_addr;
    logic [DW-1:0] ch_rdata_l, ch_rdata_r, st_din;
    logic [AW-2:0] st_addr;
    logic          st_we, st_branch;
    node_dbg_t     dbg;

    heap_node_ctrl #(.DATA_WIDTH(DW), .KEY_WIDTH(16), .ADDR_WIDTH(AW), .LEVEL(1), .LAST(0)) dut (
        .clk(clk), .rst(rst), .up(up_if), .dn(dn_if),
        .ch_addr(ch_addr), .ch_rdata_l(ch_rdata_l), .ch_rdata_r(ch_rdata_r),
        .st_din(st_din), .st_addr(st_addr), .st_we(st_we), .st_branch(st_branch),
        .dbg(dbg)
    );

    // Behavioural child store, one-cycle synchronous read.
    logic [DW-1:0] mem_l [32];
    logic [DW-1:0] mem_r [32];
    always @(posedge clk) begin
        ch_rdata_l <= mem_l[ch_addr];
        ch_rdata_r <= mem_r[ch_addr];
    end

    // ---------------- DUT: last node ----------------
    heap_node_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW-1)) ul_if ();
    heap_node_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW))   dl_if ();
    logic [AW-1:0] l_ch_addr;
    logic [DW-1:0] l_rdata, l_st_din;
    logic [AW-2:0] l_st_addr;
    logic          l_st_we, l_st_branch;
    node_dbg_t     l_dbg;
    assign l_rdata = 32'hFFFF_FFFF;   // would win every compare if it were used

    heap_node_ctrl #(.DATA_WIDTH(DW), .KEY_WIDTH(16), .ADDR_WIDTH(AW), .LEVEL(4), .LAST(1)) dut_last (
        .clk(clk), .rst(rst), .up(ul_if), .dn(dl_if),
        .ch_addr(l_ch_addr), .ch_rdata_l(l_rdata), .ch_rdata_r(l_rdata),
        .st_din(l_st_din), .st_addr(l_st_addr), .st_we(l_st_we), .st_branch(l_st_branch),
        .dbg(l_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [36:0] exp_q[$];   // {branch, addr, data} of each expected own-level write

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every own-level write must match the next expected one, in order.
    always begin
        logic [36:0] e;
        @(posedge clk);
        #1;
        if (st_we || up_if.done) check("up_done_vs_st_we", up_if.done, st_we);
        if (st_we) begin
            check("st_we_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("st_write", {st_branch, st_addr, st_din}, e);
            end
        end
    end

    // Reference model: candidates in priority order v, left, right; the
    // first one holding the largest key wins.
    task automatic model(input logic [DW-1:0] v, input logic [DW-1:0] l, input logic [DW-1:0] r,
                         output logic [DW-1:0] din, output logic fwd, output logic br);
        logic [DW-1:0] cand[3];
        int best;
        cand = '{v, l, r};
        best = 0;
        for (int i = 1; i < 3; i++)
            if (cand[i][DW-1 -: 16] > cand[best][DW-1 -: 16]) best = i;
        din = cand[best];
        fwd = (best != 0);
        br  = (best == 2);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_up_ready"},  up_if.ready,  1);
        check({tag, "_up_done"},   up_if.done,   0);
        check({tag, "_st_we"},     st_we,        0);
        check({tag, "_st_din"},    st_din,       0);
        check({tag, "_st_addr"},   st_addr,      0);
        check({tag, "_st_branch"}, st_branch,    0);
        check({tag, "_ch_addr"},   ch_addr,      0);
        check({tag, "_dn_valid"},  dn_if.valid,  0);
        check({tag, "_dn_data"},   dn_if.data,   0);
        check({tag, "_dn_addr"},   dn_if.addr,   0);
        check({tag, "_dn_branch"}, dn_if.branch, 0);
        check({tag, "_state"},     dbg.state,    STATE_IDLE);
    endtask

    // ---------------- driver ----------------
    task automatic do_cmd(input logic [DW-1:0] v, input logic [3:0] a, input logic b,
                          input logic [DW-1:0] l, input logic [DW-1:0] r,
                          input logic [DW-1:0] e_din, input logic e_fwd, input logic e_br,
                          input int bp, input logic done_in_fwd);
        int lat;
        mem_l[{a, b}] = l;
        mem_r[{a, b}] = r;
        exp_q.push_back({b, a, e_din});
        @(negedge clk);
        check("ready_before_cmd", up_if.ready, 1);
        up_if.valid  = 1'b1;
        up_if.data   = v;
        up_if.addr   = a;
        up_if.branch = b;
        @(posedge clk);
        #1;
        up_if.valid = 1'b0;
        check("ch_addr", ch_addr, {a, b});
        check("ready_busy", up_if.ready, 0);
        lat = 0;
        while (!st_we && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("write_latency", lat, 2);
        check("dn_valid_at_write", dn_if.valid, e_fwd);
        if (e_fwd) begin
            check("dn_data", dn_if.data, v);
            check("dn_addr", dn_if.addr, {a, b});
            check("dn_branch", dn_if.branch, e_br);
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                if (done_in_fwd && i == 0) dn_if.done = 1'b1;
                @(posedge clk);
                #1;
                dn_if.done = 1'b0;
                check("bp_dn_valid", dn_if.valid, 1);
                check("bp_dn_data", dn_if.data, v);
                check("bp_dn_addr", dn_if.addr, {a, b});
                check("bp_dn_branch", dn_if.branch, e_br);
            end
            @(negedge clk);
            dn_if.ready = 1'b1;
            @(posedge clk);
            #1;
            dn_if.ready = 1'b0;
            check("dn_valid_after_hs", dn_if.valid, 0);
            check("ready_in_wait", up_if.ready, 0);
            check("state_wait", dbg.state, STATE_WAIT);
            repeat (2) @(posedge clk);
            #1;
            check("wait_holds", up_if.ready, 0);
            @(negedge clk);
            dn_if.done = 1'b1;
            @(posedge clk);
            #1;
            dn_if.done = 1'b0;
            check("ready_after_done", up_if.ready, 1);
        end else begin
            check("ready_after_write", up_if.ready, 1);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [DW-1:0] v;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic [3:0]    a;
        logic          b;
        int            bp;
        logic          dfwd;
        logic [DW-1:0] e_din;
        logic          e_fwd;
        logic          e_br;
    } vec_t;
    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v, l, r, e_din;
        logic          e_fwd, e_br;
        logic [5:0]    pat;

        vecs[0] = '{32'h0009_00A1, 32'h0005_00B2, 32'h0007_00C3, 4'h1, 1'b0, 0, 1'b0, 32'h0009_00A1, 1'b0, 1'b0};
        vecs[1] = '{32'h0003_0011, 32'h0008_0022, 32'h0006_0033, 4'h2, 1'b1, 0, 1'b0, 32'h0008_0022, 1'b1, 1'b0};
        vecs[2] = '{32'h0002_0044, 32'h0006_0055, 32'h0006_0066, 4'h3, 1'b0, 1, 1'b0, 32'h0006_0055, 1'b1, 1'b0};
        vecs[3] = '{32'h0006_0077, 32'h0006_0088, 32'h0001_0099, 4'h4, 1'b1, 0, 1'b0, 32'h0006_0077, 1'b0, 1'b0};
        vecs[4] = '{32'h0003_00AA, 32'h0006_00BB, 32'h0009_00CC, 4'h5, 1'b0, 4, 1'b1, 32'h0009_00CC, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_1234, 32'h0000_5678, 32'h0000_9ABC, 4'h6, 1'b1, 0, 1'b0, 32'h0000_1234, 1'b0, 1'b0};
        vecs[6] = '{32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_0002, 4'h7, 1'b0, 2, 1'b0, 32'hFFFF_0002, 1'b1, 1'b1};
        vecs[7] = '{32'hFFFF_0003, 32'hFFFF_0004, 32'hFFFF_0005, 4'hF, 1'b1, 0, 1'b0, 32'hFFFF_0003, 1'b0, 1'b0};
        vecs[8] = '{32'h0002_0000, 32'h0007_0001, 32'h0000_0002, 4'h0, 1'b0, 3, 1'b0, 32'h0007_0001, 1'b1, 1'b0};

        for (int i = 0; i < 32; i++) begin
            mem_l[i] = '0;
            mem_r[i] = '0;
        end
        rst          = 1'b1;
        up_if.valid  = 1'b0;
        up_if.data   = '0;
        up_if.addr   = '0;
        up_if.branch = 1'b0;
        dn_if.ready  = 1'b0;
        dn_if.done   = 1'b0;
        ul_if.valid  = 1'b0;
        ul_if.data   = '0;
        ul_if.addr   = '0;
        ul_if.branch = 1'b0;
        dl_if.ready  = 1'b0;
        dl_if.done   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_last_ready", ul_if.ready, 1);
        check("reset_last_st_we", l_st_we, 0);
        check("reset_last_state", l_dbg.state, STATE_IDLE);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors.
        for (int i = 0; i < 9; i++)
            do_cmd(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].l, vecs[i].r,
                   vecs[i].e_din, vecs[i].e_fwd, vecs[i].e_br, vecs[i].bp, vecs[i].dfwd);

        // dn_done while idle is ignored.
        @(negedge clk);
        dn_if.done = 1'b1;
        @(posedge clk);
        #1;
        dn_if.done = 1'b0;
        check("idle_done_ready", up_if.ready, 1);
        check("idle_done_dn_valid", dn_if.valid, 0);

        // Reset while in RD: aborts, no write ever issues.
        mem_l[{4'hA, 1'b1}] = 32'h0009_0000;
        mem_r[{4'hA, 1'b1}] = 32'h0001_0000;
        @(negedge clk);
        up_if.valid  = 1'b1;
        up_if.data   = 32'h0002_0000;
        up_if.addr   = 4'hA;
        up_if.branch = 1'b1;
        @(posedge clk);
        #1;
        up_if.valid = 1'b0;
        check("rd_ch_addr_pre_reset", ch_addr, {4'hA, 1'b1});
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_in_rd");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rd_reset_ready_after", up_if.ready, 1);

        // Reset while in FWD: the compare-stage write has already issued.
        mem_l[{4'h9, 1'b1}] = 32'h0008_0022;
        mem_r[{4'h9, 1'b1}] = 32'h0006_0033;
        exp_q.push_back({1'b1, 4'h9, 32'h0008_0022});
        @(negedge clk);
        up_if.valid  = 1'b1;
        up_if.data   = 32'h0003_0011;
        up_if.addr   = 4'h9;
        up_if.branch = 1'b1;
        @(posedge clk);
        #1;
        up_if.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("fwd_pre_reset_dn_valid", dn_if.valid, 1);
        @(posedge clk);
        #1;
        check("fwd_pre_reset_state", dbg.state, STATE_FWD);
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_in_fwd");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Fresh command after reset.
        do_cmd(vecs[1].v, vecs[1].a, vecs[1].b, vecs[1].l, vecs[1].r,
               vecs[1].e_din, vecs[1].e_fwd, vecs[1].e_br, 2, 1'b0);

        // Randomized commands against the reference model.
        for (int n = 0; n < 40; n++) begin
            v = {16'($urandom_range(0, 15)), 16'($urandom)};
            l = {16'($urandom_range(0, 15)), 16'($urandom)};
            r = {16'($urandom_range(0, 15)), 16'($urandom)};
            model(v, l, r, e_din, e_fwd, e_br);
            do_cmd(v, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), l, r,
                   e_din, e_fwd, e_br, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // LAST=1: one-cycle latency, no child reads, never forwards.
        @(negedge clk);
        ul_if.valid  = 1'b1;
        ul_if.data   = 32'h0055_1234;
        ul_if.addr   = 4'h6;
        ul_if.branch = 1'b1;
        @(posedge clk);
        #1;
        ul_if.valid = 1'b0;
        check("last_st_we_early", l_st_we, 0);
        check("last_ready_busy", ul_if.ready, 0);
        check("last_ch_addr_0", l_ch_addr, 0);
        @(posedge clk);
        #1;
        check("last_st_we", l_st_we, 1);
        check("last_st_din", l_st_din, 32'h0055_1234);
        check("last_st_addr", l_st_addr, 4'h6);
        check("last_st_branch", l_st_branch, 1);
        check("last_up_done", ul_if.done, 1);
        check("last_dn_valid", dl_if.valid, 0);
        check("last_ready_back", ul_if.ready, 1);

        // Back-to-back commands: one accepted every other cycle.
        @(negedge clk);
        ul_if.valid = 1'b1;
        ul_if.data  = 32'h0123_0456;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            pat[i] = l_st_we;
            check("last_b2b_ch_addr", l_ch_addr, 0);
            check("last_b2b_dn_valid", dl_if.valid, 0);
        end
        ul_if.valid = 1'b0;
        check("last_b2b_pattern", pat, 6'b101010);

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
